// File: rtl/nv_nvdla_cdma_pkg.sv
// Shared CDMA constants and width helpers for the image pixel FIFO.
package nv_nvdla_cdma_pkg;

    localparam int unsigned CDMA_IMG_FIFO_DW    = 11;
    localparam int unsigned CDMA_IMG_FIFO_DEPTH = 128;

    // Ceiling log2; returns 0 for values 0 and 1.
    function automatic int unsigned cdma_clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        if (value > 32'd1) begin
            while (((value - 32'd1) >> w) != 32'd0) begin
                w = w + 32'd1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/nv_nvdla_cdma_img_pfifo_if.sv
// Write/read handshake bundle of the image pixel FIFO.
interface nv_nvdla_cdma_img_pfifo_if #(
    parameter int unsigned DW = 11
);
    logic          wr_req;
    logic          wr_ready;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic          rd_ready;
    logic [DW-1:0] rd_data;

    modport master (
        output wr_req,
        input  wr_ready,
        output wr_data,
        input  rd_req,
        output rd_ready,
        input  rd_data
    );

    modport slave (
        input  wr_req,
        output wr_ready,
        input  wr_data,
        output rd_req,
        input  rd_ready,
        output rd_data
    );
endinterface

// File: rtl/nv_nvdla_cdma_img_pfifo_ram.sv
// 1R1W storage with synchronous read; power control is accepted for macro compatibility.
module nv_nvdla_cdma_img_pfifo_ram #(
    parameter int unsigned DW      = 11,
    parameter int unsigned ENTRIES = 127,
    parameter int unsigned AW      = 7
) (
    input  logic          clk_i,
    input  logic [31:0]   pwrbus_ram_pd_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [ENTRIES];
    logic [DW-1:0] rdata_q;
    logic          unused_pd;

    assign unused_pd = ^pwrbus_ram_pd_i;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/nv_nvdla_cdma_img_pfifo.sv
// Image pixel FIFO: DEPTH-1 entry RAM plus a flopped output stage with fall-through bypass,
// registered ready, runtime occupancy limit and flush.
module nv_nvdla_cdma_img_pfifo
    import nv_nvdla_cdma_pkg::*;
#(
    parameter int unsigned DW    = CDMA_IMG_FIFO_DW,
    parameter int unsigned DEPTH = CDMA_IMG_FIFO_DEPTH,
    parameter int unsigned AW    = cdma_clog2(DEPTH),
    parameter int unsigned CW    = AW + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    nv_nvdla_cdma_img_pfifo_if.slave        bus,
    input  logic                            flush,
    input  logic [CW-1:0]                   wr_limit,
    output logic [CW-1:0]                   wr_count,
    output logic                            almost_full,
    input  logic [31:0]                     pwrbus_ram_pd
);
    localparam int unsigned   RamEntries = DEPTH - 1;
    localparam logic [AW-1:0] PtrLast    = AW'(RamEntries - 1);
    localparam logic [CW-1:0] DepthCw    = CW'(DEPTH);

    logic          rd_req_q, rd_req_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [CW-1:0] wr_count_q, wr_count_d;
    logic          wr_ready_q, wr_ready_d;
    logic          almost_full_q, almost_full_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          byp_q, byp_d;
    logic [DW-1:0] byp_data_q, byp_data_d;

    logic [CW-1:0] eff_limit;
    logic          wr_acc, rd_pop, out_free, ram_nz, ram_we;
    logic [DW-1:0] ram_rdata, ram_head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        eff_limit = (wr_limit == '0 || wr_limit > DepthCw) ? DepthCw : wr_limit;
        wr_acc    = bus.wr_req && wr_ready_q;
        rd_pop    = rd_req_q && bus.rd_ready;
        out_free  = !rd_req_q || rd_pop;
        ram_nz    = wr_count_q > CW'(rd_req_q);
        // The RAM read register can be stale when the head was written in the read cycle.
        ram_head  = byp_q ? byp_data_q : ram_rdata;
        ram_we    = wr_acc && !flush && !(out_free && !ram_nz);

        rd_req_d   = rd_req_q;
        rd_data_d  = rd_data_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        wr_count_d = wr_count_q;
        byp_data_d = bus.wr_data;

        if (out_free) begin
            if (ram_nz) begin
                rd_req_d  = 1'b1;
                rd_data_d = ram_head;
                rd_ptr_d  = ptr_inc(rd_ptr_q);
            end else if (wr_acc) begin
                rd_req_d  = 1'b1;
                rd_data_d = bus.wr_data;
            end else begin
                rd_req_d  = 1'b0;
            end
        end

        if (ram_we) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end

        if (wr_acc && !rd_pop) begin
            wr_count_d = wr_count_q + 1'b1;
        end else if (!wr_acc && rd_pop) begin
            wr_count_d = wr_count_q - 1'b1;
        end

        if (flush) begin
            rd_req_d   = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            wr_count_d = '0;
        end

        wr_ready_d    = wr_count_d < eff_limit;
        almost_full_d = wr_count_d >= (eff_limit - 1'b1);
        byp_d         = ram_we && (wr_ptr_q == rd_ptr_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_req_q      <= 1'b0;
            wr_count_q    <= '0;
            wr_ready_q    <= 1'b0;
            almost_full_q <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            byp_q         <= 1'b0;
        end else begin
            rd_req_q      <= rd_req_d;
            wr_count_q    <= wr_count_d;
            wr_ready_q    <= wr_ready_d;
            almost_full_q <= almost_full_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            byp_q         <= byp_d;
        end
    end

    // Payload flops carry no reset; they are only observed while rd_req is high.
    always_ff @(posedge clk) begin
        rd_data_q  <= rd_data_d;
        byp_data_q <= byp_data_d;
    end

    nv_nvdla_cdma_img_pfifo_ram #(
        .DW      (DW),
        .ENTRIES (RamEntries),
        .AW      (AW)
    ) u_ram (
        .clk_i           (clk),
        .pwrbus_ram_pd_i (pwrbus_ram_pd),
        .we_i            (ram_we),
        .waddr_i         (wr_ptr_q),
        .wdata_i         (bus.wr_data),
        .raddr_i         (rd_ptr_d),
        .rdata_o         (ram_rdata)
    );

    assign bus.wr_ready = wr_ready_q;
    assign bus.rd_req   = rd_req_q;
    assign bus.rd_data  = rd_data_q;
    assign wr_count     = wr_count_q;
    assign almost_full  = almost_full_q;

endmodule

// File: tb/tb_nv_nvdla_cdma_img_pfifo.sv
// Self-checking bench: directed vector table, corner-case sequences and random traffic
// compared against a queue-based reference model.
module tb_nv_nvdla_cdma_img_pfifo;
    import nv_nvdla_cdma_pkg::*;

    localparam int unsigned DW    = CDMA_IMG_FIFO_DW;
    localparam int unsigned DEPTH = CDMA_IMG_FIFO_DEPTH;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [CW-1:0] wr_limit;
    logic [CW-1:0] wr_count;
    logic          almost_full;
    logic [31:0]   pwrbus_ram_pd;

    nv_nvdla_cdma_img_pfifo_if #(.DW(DW)) bus ();

    nv_nvdla_cdma_img_pfifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .flush         (flush),
        .wr_limit      (wr_limit),
        .wr_count      (wr_count),
        .almost_full   (almost_full),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [DW-1:0] wd;
        logic          rr;
        logic          fl;
        logic [CW-1:0] lim;
        logic          e_req;
        logic [DW-1:0] e_data;
        int            e_cnt;
        logic          e_ready;
        logic          e_af;
    } vec_t;

    vec_t          tbl [11];
    logic [DW-1:0] mq [$];
    logic          m_ready = 1'b0;
    logic          m_af    = 1'b0;
    int            n_cmp   = 0;
    int            n_bad   = 0;
    int            pops    = 0;

    function automatic int unsigned eff(input int unsigned l);
        return (l == 0 || l > DEPTH) ? DEPTH : l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        check("wr_count", 32'(wr_count), 32'(mq.size()));
        check("rd_req", 32'(bus.rd_req), 32'(mq.size() > 0));
        check("wr_ready", 32'(bus.wr_ready), 32'(m_ready));
        check("almost_full", 32'(almost_full), 32'(m_af));
        if (mq.size() > 0) check("rd_data", 32'(bus.rd_data), 32'(mq[0]));
    endtask

    // One clock: drive inputs, advance the reference model by the same rules, compare.
    task automatic step(input logic wr, input logic [DW-1:0] wd, input logic rr,
                        input logic fl, input logic [CW-1:0] lim);
        bit acc, pop;
        bus.wr_req   = wr;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        flush        = fl;
        wr_limit     = lim;
        acc = wr && m_ready;
        pop = rr && (mq.size() > 0);
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            m_ready = 1'b0;
            m_af    = 1'b0;
        end else begin
            if (fl) begin
                mq.delete();
            end else begin
                if (pop) begin
                    void'(mq.pop_front());
                    pops++;
                end
                if (acc) mq.push_back(wd);
            end
            m_ready = mq.size() < eff(32'(lim));
            m_af    = mq.size() >= (eff(32'(lim)) - 1);
        end
        compare_model();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset         = 1'b1;
        flush         = 1'b0;
        wr_limit      = '0;
        pwrbus_ram_pd = '0;
        bus.wr_req    = 1'b0;
        bus.wr_data   = '0;
        bus.rd_ready  = 1'b0;

        // wr     wd       rr    fl    lim    e_req e_data   cnt rdy   af
        tbl[0]  = '{1'b1, 11'h5A5, 1'b0, 1'b0, 8'd0, 1'b1, 11'h5A5, 1, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 11'h123, 1'b0, 1'b0, 8'd0, 1'b1, 11'h5A5, 2, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 11'h000, 1'b1, 1'b0, 8'd0, 1'b1, 11'h123, 1, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 11'h0AA, 1'b1, 1'b0, 8'd0, 1'b1, 11'h0AA, 1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 11'h000, 1'b1, 1'b0, 8'd0, 1'b0, 11'h000, 0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 11'h7FF, 1'b1, 1'b0, 8'd0, 1'b1, 11'h7FF, 1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 11'h001, 1'b0, 1'b1, 8'd0, 1'b0, 11'h000, 0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 11'h002, 1'b0, 1'b0, 8'd1, 1'b1, 11'h002, 1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 11'h003, 1'b0, 1'b0, 8'd1, 1'b1, 11'h002, 1, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 11'h000, 1'b1, 1'b0, 8'd1, 1'b0, 11'h000, 0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 11'h000, 1'b0, 1'b0, 8'd0, 1'b0, 11'h000, 0, 1'b1, 1'b0};

        // Reset: ready held low, then rises on the first clock after release.
        step(1'b1, 11'h111, 1'b1, 1'b0, 8'd0);
        step(1'b1, 11'h222, 1'b1, 1'b0, 8'd0);
        check("reset_wr_ready", 32'(bus.wr_ready), 32'd0);
        reset = 1'b0;
        step(1'b0, '0, 1'b0, 1'b0, 8'd0);
        check("post_reset_wr_ready", 32'(bus.wr_ready), 32'd1);

        // Directed table, including single-write latency and limit=1 corners.
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].wr, tbl[i].wd, tbl[i].rr, tbl[i].fl, tbl[i].lim);
            check($sformatf("tbl%0d_req", i), 32'(bus.rd_req), 32'(tbl[i].e_req));
            check($sformatf("tbl%0d_cnt", i), 32'(wr_count), 32'(tbl[i].e_cnt));
            check($sformatf("tbl%0d_rdy", i), 32'(bus.wr_ready), 32'(tbl[i].e_ready));
            check($sformatf("tbl%0d_af", i), 32'(almost_full), 32'(tbl[i].e_af));
            if (tbl[i].e_req) check($sformatf("tbl%0d_data", i), 32'(bus.rd_data),
                                    32'(tbl[i].e_data));
        end

        // Fill to DEPTH with reads stalled.
        for (int i = 0; i < 128; i++) begin
            step(1'b1, DW'(i), 1'b0, 1'b0, 8'd0);
            if (i == 125) check("af_at_126", 32'(almost_full), 32'd0);
            if (i == 126) check("af_at_127", 32'(almost_full), 32'd1);
        end
        check("fill_cnt", 32'(wr_count), 32'd128);
        check("fill_ready", 32'(bus.wr_ready), 32'd0);

        // Drain in order, one per cycle.
        for (int i = 0; i < 128; i++) begin
            check("drain_data", 32'(bus.rd_data), 32'(i));
            step(1'b0, '0, 1'b1, 1'b0, 8'd0);
        end
        check("drain_req", 32'(bus.rd_req), 32'd0);
        check("drain_cnt", 32'(wr_count), 32'd0);

        // Continuous writes with 50% read backpressure.
        pops = 0;
        for (int i = 0; i < 2000; i++) begin
            step(1'b1, DW'($urandom), 1'($urandom_range(0, 1)), 1'b0, 8'd0);
        end
        check("ptr_wraps", 32'(pops >= 7 * (DEPTH - 1)), 32'd1);
        k = 0;
        while (mq.size() > 0 && k < 300) begin
            step(1'b0, '0, 1'b1, 1'b0, 8'd0);
            k++;
        end
        check("stream_drain_cnt", 32'(wr_count), 32'd0);

        // Random traffic with limit changes (including clamped values) and rare flushes.
        begin
            logic [CW-1:0] lim;
            lim = '0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 31) == 0) lim = CW'($urandom_range(0, 255));
                step(1'($urandom_range(0, 3) != 0), DW'($urandom), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 63) == 0), lim);
            end
        end
        step(1'b0, '0, 1'b0, 1'b1, 8'd0);

        // Limit 16, write until stall, then tighten to 8.
        k = 0;
        while (bus.wr_ready && k < 64) begin
            step(1'b1, DW'(k), 1'b0, 1'b0, 8'd16);
            k++;
        end
        check("lim16_cnt", 32'(wr_count), 32'd16);
        for (int i = 0; i < 3; i++) step(1'b1, 11'h7AA, 1'b0, 1'b0, 8'd8);
        check("lim8_ready", 32'(bus.wr_ready), 32'd0);
        check("lim8_cnt", 32'(wr_count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check("lim8_data", 32'(bus.rd_data), 32'(i));
            step(1'b0, '0, 1'b1, 1'b0, 8'd8);
            if (i == 7) check("lim8_ready_at8", 32'(bus.wr_ready), 32'd0);
            if (i == 8) check("lim8_ready_at7", 32'(bus.wr_ready), 32'd1);
        end

        // Flush at count 50 together with write and read.
        for (int i = 0; i < 50; i++) step(1'b1, DW'(i + 100), 1'b0, 1'b0, 8'd0);
        check("pre_flush_cnt", 32'(wr_count), 32'd50);
        step(1'b1, 11'h7EE, 1'b1, 1'b1, 8'd0);
        check("flush_cnt", 32'(wr_count), 32'd0);
        check("flush_req", 32'(bus.rd_req), 32'd0);
        check("flush_ready", 32'(bus.wr_ready), 32'd1);
        step(1'b1, 11'h3C3, 1'b0, 1'b0, 8'd0);
        check("post_flush_req", 32'(bus.rd_req), 32'd1);
        check("post_flush_data", 32'(bus.rd_data), 32'h3C3);
        step(1'b0, '0, 1'b1, 1'b0, 8'd0);
        check("post_flush_cnt", 32'(wr_count), 32'd0);

        // Reset mid-transfer behaves like flush.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(i), 1'b0, 1'b0, 8'd0);
        reset = 1'b1;
        step(1'b1, 11'h055, 1'b1, 1'b0, 8'd0);
        reset = 1'b0;
        step(1'b1, 11'h066, 1'b0, 1'b0, 8'd0);
        check("mid_reset_cnt", 32'(wr_count), 32'd0);
        step(1'b1, 11'h077, 1'b0, 1'b0, 8'd0);
        check("mid_reset_data", 32'(bus.rd_data), 32'h077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
